// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle CPU control FSM.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: opcode/funct constants, ALUOp/mux encodings, the 4-bit state enum.
package multicycle_control_pkg;

  // Opcodes, Instr[15:12]
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1100;
  localparam logic [3:0] OP_BEQ   = 4'b0010;
  localparam logic [3:0] OP_J     = 4'b0011;

  // R-type funct selecting the multi-cycle multiplier, Instr[3:0]
  localparam logic [3:0] FUNCT_MUL = 4'b1010;

  // ALUOp encodings seen by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_MUL_WAIT = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

endpackage

// File: rtl/multicycle_control_mul_stall_counter.sv
// Down-counter that holds the FSM in MUL_WAIT while the multiplier works.
// Latency: load/decrement take effect on the next rising edge; zero is combinational.
// Backpressure: none; decrement saturates at zero so an extra dec cycle is harmless.
// Ports: clk, rst_n (async active-low), load + load_val, dec, zero (count==0).
module mul_stall_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/write-back sequencing for the 16-bit CPU.
// Latency: outputs are a Moore decode of state (FETCH's IRWrite/PCWrite also follow MemReady).
// Backpressure: holds FETCH/MEM_RD/MEM_WR until MemReady; holds MUL_WAIT for MUL_CYCLES cycles.
// Ports: Clock, Reset_n, Instr/Zero/MemReady in; PC, memory, IR, regfile, ALU mux/op controls,
//        Busy (multiply stall) and Halt (illegal opcode trap) out.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [15:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic [1:0]  PCSrc,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        Busy,
  output logic        Halt
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] opcode, funct;
  logic       cnt_load, cnt_dec, cnt_zero;
  // Zero is combined with PCWriteCond in the datapath; the middle instruction
  // bits are register fields that never influence sequencing.
  logic       unused_inputs;

  assign opcode        = Instr[15:12];
  assign funct         = Instr[3:0];
  assign unused_inputs = ^{Instr[11:4], Zero};

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  mul_stall_counter #(.CNT_W(CNT_W)) u_mul_cnt (
    .clk      (Clock),
    .rst_n    (Reset_n),
    .load     (cnt_load),
    .load_val (MUL_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt   = state;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSrc       = PCSRC_ALU;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    Busy        = 1'b0;
    Halt        = 1'b0;

    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_ONE;
        // IR and PC+1 only commit on the cycle the read completes
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BROFF;
        unique case (opcode)
          OP_RTYPE:    state_nxt = S_EXEC_R;
          OP_ADDI:     state_nxt = S_EXEC_I;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:      state_nxt = S_BRANCH;
          OP_J:        state_nxt = S_JUMP;
          default:     state_nxt = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
        if (funct == FUNCT_MUL) begin
          cnt_load  = 1'b1;
          state_nxt = S_MUL_WAIT;
        end else begin
          state_nxt = S_WB_R;
        end
      end
      S_MUL_WAIT: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
        Busy    = 1'b1;
        cnt_dec = 1'b1;
        // Counter was loaded with MUL_CYCLES-1, so this state lasts MUL_CYCLES cycles
        if (cnt_zero) state_nxt = S_WB_R;
      end
      S_WB_R: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = S_WB_I;
      end
      S_WB_I: begin
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        // Only LW/SW reach here; bit 14 is the sole difference between them
        state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MemReady) state_nxt = S_WB_MEM;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_nxt = S_FETCH;
      end
      S_WB_MEM: begin
        MemToReg  = 1'b1;
        RegWrite  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = PCSRC_ALUOUT;
        state_nxt   = S_FETCH;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSrc     = PCSRC_JUMP;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        Halt = 1'b1;
      end
      default: begin
        // Unused encodings are treated as a trap
        state_nxt = S_HALT;
      end
    endcase
  end

endmodule
